am_class_fetch_ctrl: RTL
========================

# am_class_fetch_ctrl

Sequencer that streams class hypervectors from the class-HV memory into the associative memory for one similarity search per start. It sits between the encoder start pulse, the class-HV SRAM and the AM `class_hv` valid/ready port. It tracks the dimension-expansion segment across successive searches. A 2-entry prefetch buffer sustains one HV per cycle under backpressure.

## Interface
- `HVDimension`, 512, hypervector width.
- `DataWidth`, 8, width of the class-count field.
- `NumClassMax`, 32, maximum classes. `ClassIdxWidth = $clog2(NumClassMax)`.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: search request. Accepted only when `busy_o`=0.
- `clr_i` in 1: synchronous abort/flush.
- `num_class_i` in DataWidth: classes per pass. Sampled at accepted start.
- `extend_enable_i` in 1: dimension expansion on.
- `extend_count_i` in 5: number of expansion segments. Sampled at accepted start.
- `busy_o` out 1: pass in progress.
- `stall_o` out 1: `busy_o && start_i`.
- `ext_idx_o` out 5: segment index of the current or next pass.
- `ext_last_o` out 1: current or next pass is the final segment.
- `mem_req_o` out 1: SRAM read strobe. Always accepted.
- `mem_addr_o` out 5+ClassIdxWidth: `{ext_idx, class_idx}`.
- `mem_rdata_i` in HVDimension: read data, valid exactly 1 cycle after `mem_req_o`.
- `class_hv_o` out HVDimension: buffer head.
- `class_hv_valid_o` out 1: buffer non-empty.
- `class_hv_ready_i` in 1: AM accepts.
- `done_o` out 1: one-cycle pulse, pass complete.
- `cfg_err_o` out 1: one-cycle pulse, start rejected.

## Operation
- **States:** IDLE, FETCH, DRAIN.
- **IDLE + `start_i`:** run the config check.
  - Error conditions: `num_class_i`==0, `num_class_i`>NumClassMax, or `extend_enable_i` && `extend_count_i`==0.
  - On error: `cfg_err_o` pulses next cycle and the block stays in IDLE.
  - Otherwise: latch the config, reset `class_idx` to 0, and enter FETCH.
- **FETCH:** issue a read when `occupancy + inflight < 2`, with address `{ext_idx, class_idx}`. Then increment `class_idx`.
  - After the request for `class_idx == num_class-1`, enter DRAIN.
  - Responses are written to the buffer the cycle they arrive.
- **DRAIN:** no requests are issued. When the last HV handshakes (`valid && ready`, buffer becomes empty, nothing inflight), go to IDLE and pulse `done_o`.
- **Buffer:** 2-entry FIFO.
  - Push and pop in the same cycle is legal. Occupancy is unchanged and data order is preserved.
  - The credit rule guarantees no overflow. An overflow is an assertion failure.
- **`ext_idx` update on `done_o`:**
  - If `extend_enable`: `ext_idx <= (ext_idx+1 >= extend_count) ? 0 : ext_idx+1`.
  - Else: `ext_idx <= 0`.
  - In IDLE, `extend_enable_i`=0 forces `ext_idx` to 0.
- **`ext_last_o`:** `!extend_enable_i || ext_idx == extend_count_i-1`.
- **`clr_i`** (highest priority, any state):
  - Next cycle: IDLE, buffer empty, `ext_idx`=0.
  - A response arriving the cycle after `clr_i` is discarded.
  - No `done_o` pulse.
- **Start while busy:** ignored and `stall_o`=1. A start in the cycle `done_o` is high is accepted, because `busy_o` is already 0.

## Timing
- **Reset values:** state IDLE. All outputs 0: `busy_o`, `stall_o`, `mem_req_o`, `mem_addr_o`, `class_hv_o`, `class_hv_valid_o`, `done_o`, `cfg_err_o`, `ext_idx_o`. `ext_last_o` follows its combinational definition.
- **Start sequence:** start accepted at cycle t.
  - t+1: `busy_o`=1, first `mem_req_o`.
  - t+2: `class_hv_valid_o`=1.
- **Throughput:** with `class_hv_ready_i` held high, one HV per cycle. A pass of N classes shows valid on t+2 … t+N+1.
- **Completion:** last handshake at cycle u. At u+1: `done_o`=1, `busy_o`=0, `ext_idx_o` updated.
- **Minimum pass:** N=1 gives `done_o` at t+3.
- **Backpressure:** `class_hv_o` and `class_hv_valid_o` stay stable while valid && !ready.
- **`mem_req_o`:** combinational from the registered state and credit.
- **`mem_addr_o`:** meaningful only while `mem_req_o`=1. Otherwise it holds its last value.

## Test plan
- **Basic pass:** `num_class`=3, no expansion, ready high, SRAM word = address. Required: addresses 0,1,2; HVs valid at t+2..t+4; `done_o` at t+5; `ext_idx_o` stays 0.
- **Backpressure:** `num_class`=4, ready toggles 1,0,0,1,… Required: HV order 0..3 with no loss or duplication; data stable while stalled; never more than 2 entries plus inflight.
- **Expansion:** `extend_count`=3, `num_class`=2, four back-to-back starts.
  - Pass 1: `ext_idx` 0, addresses {0,0},{0,1}.
  - Pass 2: `ext_idx` 1.
  - Pass 3: `ext_idx` 2 with `ext_last_o`=1.
  - Pass 4: wraps to `ext_idx` 0.
- **Config errors:** `num_class`=0, then `num_class`=33, then expansion with `extend_count`=0. Required for each: `cfg_err_o` pulse, no `mem_req_o`, `busy_o` stays 0.
- **Abort:** `clr_i` asserted while one response is inflight and one buffered. Required next cycle: valid 0, IDLE, `ext_idx` 0, no `done_o`. The late response is dropped, and a new start runs cleanly.
- **Start handling:**
  - Start held during a pass gives `stall_o`=1 and no restart.
  - Start coincident with `done_o` launches the next pass at the following cycle.
  - Async `rst_i` mid-pass zeroes all outputs immediately.

Source files
------------

// File: rtl/am_class_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// am_class_fetch_ctrl
//
// Streams the class hypervectors of one similarity search from the class-HV
// SRAM into the associative memory. Each accepted start reads num_class words
// at {ext_idx, class_idx} and presents them on a valid/ready port. A 2-entry
// FIFO plus the one-cycle SRAM latency keep one HV per cycle flowing under
// backpressure. The dimension-expansion segment index (ext_idx) advances by
// one per completed pass and wraps at extend_count.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i, clr_i        search request (taken only when idle), sync abort
//   num_class_i           classes per pass, sampled at an accepted start
//   extend_enable_i       dimension expansion on
//   extend_count_i        number of expansion segments, sampled at start
//   busy_o, stall_o       pass in progress, start seen while busy
//   ext_idx_o, ext_last_o current/next segment index, final-segment flag
//   mem_req_o, mem_addr_o SRAM read strobe and address {ext_idx, class_idx}
//   mem_rdata_i           SRAM data, valid the cycle after mem_req_o
//   class_hv_o/valid/ready  HV stream towards the associative memory
//   done_o, cfg_err_o     one-cycle pulses: pass complete, start rejected
// -----------------------------------------------------------------------------
module am_class_fetch_ctrl #(
  parameter int HVDimension = 512,
  parameter int DataWidth   = 8,
  parameter int NumClassMax = 32,
  localparam int ClassIdxWidth = $clog2(NumClassMax),
  localparam int AddrWidth     = 5 + ClassIdxWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   clr_i,
  input  logic [DataWidth-1:0]   num_class_i,
  input  logic                   extend_enable_i,
  input  logic [4:0]             extend_count_i,
  output logic                   busy_o,
  output logic                   stall_o,
  output logic [4:0]             ext_idx_o,
  output logic                   ext_last_o,
  output logic                   mem_req_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  input  logic [HVDimension-1:0] mem_rdata_i,
  output logic [HVDimension-1:0] class_hv_o,
  output logic                   class_hv_valid_o,
  input  logic                   class_hv_ready_i,
  output logic                   done_o,
  output logic                   cfg_err_o
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } state_e;

  localparam logic [ClassIdxWidth-1:0] ClassOne = 1;

  state_e                   state_reg, state_next;
  logic [ClassIdxWidth-1:0] class_idx_reg, class_idx_next;
  logic [ClassIdxWidth-1:0] last_idx_reg, last_idx_next;
  logic                     ext_en_reg, ext_en_next;
  logic [4:0]               ext_cnt_reg, ext_cnt_next;
  logic [4:0]               ext_idx_reg, ext_idx_next;
  logic                     inflight_reg, inflight_next;
  logic [1:0]               occ_reg, occ_next;
  logic                     rd_ptr_reg, rd_ptr_next;
  logic                     wr_ptr_reg, wr_ptr_next;
  logic                     done_reg, done_next;
  logic                     cfg_err_reg, cfg_err_next;
  logic [AddrWidth-1:0]     addr_hold_reg, addr_hold_next;

  logic [HVDimension-1:0]   buf_mem [2];

  logic                     credit_ok;
  logic                     req;
  logic [AddrWidth-1:0]     req_addr;
  logic                     hv_valid;
  logic                     pop;
  logic                     pop_buf;
  logic                     push_buf;
  logic                     cfg_bad;
  logic [5:0]               ext_inc;
  logic                     ext_wrap;
  logic [4:0]               ext_cnt_m1;

  // Credit counts buffered entries plus the response on its way, so a read
  // is only issued when a slot is guaranteed for it.
  assign credit_ok = (occ_reg + {1'b0, inflight_reg}) < 2'd2;
  assign req       = (state_reg == StFetch) && credit_ok;
  assign req_addr  = {ext_idx_reg, class_idx_reg};

  // The arriving response is exposed directly when the FIFO is empty, which
  // gives valid two cycles after the accepted start. If it is not consumed it
  // is written into the FIFO and reappears unchanged at the head.
  assign hv_valid = (occ_reg != 2'd0) || inflight_reg;
  assign pop      = hv_valid && class_hv_ready_i;
  assign pop_buf  = pop && (occ_reg != 2'd0);
  assign push_buf = inflight_reg && !((occ_reg == 2'd0) && class_hv_ready_i);

  assign cfg_bad = (num_class_i == '0) ||
                   (32'(num_class_i) > NumClassMax) ||
                   (extend_enable_i && (extend_count_i == 5'd0));

  assign ext_inc    = {1'b0, ext_idx_reg} + 6'd1;
  assign ext_wrap   = ext_inc >= {1'b0, ext_cnt_reg};
  assign ext_cnt_m1 = extend_count_i - 5'd1;

  always_comb begin
    state_next     = state_reg;
    class_idx_next = class_idx_reg;
    last_idx_next  = last_idx_reg;
    ext_en_next    = ext_en_reg;
    ext_cnt_next   = ext_cnt_reg;
    ext_idx_next   = ext_idx_reg;
    inflight_next  = req;
    occ_next       = occ_reg + {1'b0, push_buf} - {1'b0, pop_buf};
    rd_ptr_next    = rd_ptr_reg ^ pop_buf;
    wr_ptr_next    = wr_ptr_reg ^ push_buf;
    done_next      = 1'b0;
    cfg_err_next   = 1'b0;
    addr_hold_next = req ? req_addr : addr_hold_reg;

    case (state_reg)
      StIdle: begin
        if (!extend_enable_i) begin
          ext_idx_next = '0;
        end
        if (start_i) begin
          if (cfg_bad) begin
            cfg_err_next = 1'b1;
          end else begin
            state_next     = StFetch;
            class_idx_next = '0;
            last_idx_next  = ClassIdxWidth'(num_class_i - DataWidth'(1));
            ext_en_next    = extend_enable_i;
            ext_cnt_next   = extend_count_i;
            // A shrunk segment count must not leave the index out of range.
            if (extend_enable_i && (ext_idx_reg >= extend_count_i)) begin
              ext_idx_next = '0;
            end
          end
        end
      end
      StFetch: begin
        if (req) begin
          class_idx_next = class_idx_reg + ClassOne;
          if (class_idx_reg == last_idx_reg) begin
            state_next = StDrain;
          end
        end
      end
      StDrain: begin
        // No reads are issued here, so an empty FIFO after this handshake
        // means the pass is fully delivered.
        if (pop && (occ_next == 2'd0)) begin
          state_next = StIdle;
          done_next  = 1'b1;
          if (ext_en_reg) begin
            ext_idx_next = ext_wrap ? 5'd0 : ext_inc[4:0];
          end else begin
            ext_idx_next = '0;
          end
        end
      end
      default: begin
        state_next = StIdle;
      end
    endcase

    // Abort wins over everything; clearing inflight drops the late response.
    if (clr_i) begin
      state_next    = StIdle;
      inflight_next = 1'b0;
      occ_next      = 2'd0;
      rd_ptr_next   = 1'b0;
      wr_ptr_next   = 1'b0;
      ext_idx_next  = '0;
      done_next     = 1'b0;
      cfg_err_next  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= StIdle;
      class_idx_reg <= '0;
      last_idx_reg  <= '0;
      ext_en_reg    <= 1'b0;
      ext_cnt_reg   <= '0;
      ext_idx_reg   <= '0;
      inflight_reg  <= 1'b0;
      occ_reg       <= 2'd0;
      rd_ptr_reg    <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      done_reg      <= 1'b0;
      cfg_err_reg   <= 1'b0;
      addr_hold_reg <= '0;
    end else begin
      state_reg     <= state_next;
      class_idx_reg <= class_idx_next;
      last_idx_reg  <= last_idx_next;
      ext_en_reg    <= ext_en_next;
      ext_cnt_reg   <= ext_cnt_next;
      ext_idx_reg   <= ext_idx_next;
      inflight_reg  <= inflight_next;
      occ_reg       <= occ_next;
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      done_reg      <= done_next;
      cfg_err_reg   <= cfg_err_next;
      addr_hold_reg <= addr_hold_next;
    end
  end

  // FIFO storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push_buf) begin
      buf_mem[wr_ptr_reg] <= mem_rdata_i;
    end
  end

  assign busy_o           = (state_reg != StIdle);
  assign stall_o          = busy_o && start_i;
  assign ext_idx_o        = ext_idx_reg;
  assign ext_last_o       = !extend_enable_i || (ext_idx_reg == ext_cnt_m1);
  assign mem_req_o        = req;
  assign mem_addr_o       = req ? req_addr : addr_hold_reg;
  assign class_hv_valid_o = hv_valid;
  assign class_hv_o       = (occ_reg != 2'd0) ? buf_mem[rd_ptr_reg] :
                            (inflight_reg ? mem_rdata_i : '0);
  assign done_o           = done_reg;
  assign cfg_err_o        = cfg_err_reg;

  // The credit rule must never let a push land on a full FIFO.
  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_buf && !pop_buf && (occ_reg == 2'd2)));

endmodule
